// File: rtl/cpu_types_pkg.sv
// Shared pipeline types: inter-stage payload structs with matching widths and the flush counter type.
// Payload structs are opaque to pipe_stage_reg; it only needs their $bits.
package cpu_types_pkg;

  typedef logic [15:0] flush_cnt_t;
  localparam flush_cnt_t FLUSH_CNT_MAX = 16'hFFFF;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } ifid_t;
  localparam int IFID_W = $bits(ifid_t);

  typedef struct packed {
    logic [31:0] pc;
    logic [4:0]  rd;
    logic [31:0] rs1_val;
    logic [31:0] rs2_val;
    logic [31:0] imm;
    logic [3:0]  alu_op;
    logic        mem_rd;
    logic        mem_wr;
    logic        reg_wr;
  } idex_t;
  localparam int IDEX_W = $bits(idex_t);

  typedef struct packed {
    logic [31:0] alu_res;
    logic [31:0] store_val;
    logic [4:0]  rd;
    logic        mem_rd;
    logic        mem_wr;
    logic        reg_wr;
  } exmem_t;
  localparam int EXMEM_W = $bits(exmem_t);

  typedef struct packed {
    logic [31:0] wb_val;
    logic [4:0]  rd;
    logic        reg_wr;
  } memwb_t;
  localparam int MEMWB_W = $bits(memwb_t);

  function automatic flush_cnt_t flush_cnt_inc(input flush_cnt_t c);
    return (c == FLUSH_CNT_MAX) ? c : c + 16'd1;
  endfunction

endpackage

// File: rtl/pipe_slot.sv
// One valid+data register of the pipeline chain; flush beats load, load beats vacate, else hold.
// Latency 1 cycle; no handshake of its own, the parent decides when it loads or empties.
module pipe_slot
  import cpu_types_pkg::*;
#(
  parameter int            DW     = 32,
  parameter logic [DW-1:0] BUBBLE = '0
) (
  input  logic          CLK,
  input  logic          nRST,
  input  logic          flush,
  input  logic          load,
  input  logic          vacate,
  input  logic [DW-1:0] din,
  output logic          vld,
  output logic [DW-1:0] dat
);

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      vld <= 1'b0;
      dat <= BUBBLE;
    end else if (flush) begin
      vld <= 1'b0;
      dat <= BUBBLE;
    end else if (load) begin
      vld <= 1'b1;
      dat <= din;
    end else if (vacate) begin
      vld <= 1'b0;
      dat <= BUBBLE;
    end
  end

endmodule

// File: rtl/pipe_stage_reg.sv
// Elastic DEPTH-slot pipeline register with bubble collapsing, per-slot squash, flush and optional skid.
// Latency DEPTH cycles; in_ready follows slot0 freedom (SKID=0) or the skid register (SKID=1).
module pipe_stage_reg
  import cpu_types_pkg::*;
#(
  parameter int            DW     = 32,
  parameter int            DEPTH  = 1,
  parameter logic [DW-1:0] BUBBLE = '0,
  parameter int            SKID   = 0
) (
  input  logic                              CLK,
  input  logic                              nRST,
  input  logic                              in_valid,
  output logic                              in_ready,
  input  logic [DW-1:0]                     in_data,
  input  logic                              flush,
  input  logic [DEPTH-1:0]                  flush_mask,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic [DW-1:0]                     out_data,
  output logic [$clog2(DEPTH+SKID+1)-1:0]   occupancy,
  output flush_cnt_t                        flush_cnt
);

  localparam int OW = $clog2(DEPTH+SKID+1);

  logic [DEPTH-1:0] v;
  logic [DEPTH-1:0] mv;
  logic [DEPTH-1:0] ld;
  logic [DEPTH-1:0] vac;
  logic [DEPTH-1:0] nv;
  logic [DW-1:0]    d   [DEPTH];
  logic [DW-1:0]    din [DEPTH];
  logic             free0;
  logic             accept;
  logic             skid_v;
  logic [DW-1:0]    skid_d;
  logic             skid_nxt;
  logic [OW-1:0]    occ_nxt;

  // Walk from the output side back: a slot moves when the one ahead is free after this edge.
  always_comb begin : p_advance
    logic dn_free;
    logic mv_i;
    mv      = '0;
    dn_free = out_ready;
    mv_i    = 1'b0;
    for (int i = DEPTH-1; i >= 0; i--) begin
      mv_i    = v[i] && dn_free && ((i == DEPTH-1) || !flush_mask[i]);
      mv[i]   = mv_i;
      dn_free = !v[i] || flush_mask[i] || mv_i;
    end
    free0 = dn_free;
  end

  assign in_ready = nRST && ((SKID != 0) ? !skid_v : (!flush && free0));
  assign accept   = in_valid && in_ready;

  always_comb begin : p_load
    ld  = '0;
    vac = '0;
    for (int i = 0; i < DEPTH; i++) din[i] = BUBBLE;
    ld[0]  = !flush && free0 && (skid_v || accept);
    din[0] = skid_v ? skid_d : in_data;
    for (int i = 1; i < DEPTH; i++) begin
      ld[i]  = !flush && mv[i-1];
      din[i] = d[i-1];
    end
    for (int i = 0; i < DEPTH; i++) vac[i] = mv[i] || flush_mask[i];
  end

  for (genvar g = 0; g < DEPTH; g++) begin : g_slot
    pipe_slot #(
      .DW     (DW),
      .BUBBLE (BUBBLE)
    ) u_slot (
      .CLK    (CLK),
      .nRST   (nRST),
      .flush  (flush),
      .load   (ld[g]),
      .vacate (vac[g]),
      .din    (din[g]),
      .vld    (v[g]),
      .dat    (d[g])
    );
  end

  if (SKID != 0) begin : g_skid
    logic          sv;
    logic [DW-1:0] sd;
    // The skid only fills when slot0 is stuck; it always drains before new input is taken.
    always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
        sv <= 1'b0;
        sd <= BUBBLE;
      end else if (flush || (sv && free0)) begin
        sv <= 1'b0;
        sd <= BUBBLE;
      end else if (accept && !free0) begin
        sv <= 1'b1;
        sd <= in_data;
      end
    end
    assign skid_v = sv;
    assign skid_d = sd;
  end else begin : g_noskid
    assign skid_v = 1'b0;
    assign skid_d = BUBBLE;
  end

  always_comb begin : p_occ
    nv = '0;
    for (int i = 0; i < DEPTH; i++) nv[i] = !flush && (ld[i] || (v[i] && !vac[i]));
    skid_nxt = (SKID != 0) && !flush && !free0 && (skid_v || accept);
    occ_nxt  = OW'(skid_nxt);
    for (int i = 0; i < DEPTH; i++) occ_nxt = occ_nxt + OW'(nv[i]);
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      occupancy <= '0;
      flush_cnt <= '0;
    end else begin
      occupancy <= occ_nxt;
      if (flush) flush_cnt <= flush_cnt_inc(flush_cnt);
    end
  end

  assign out_valid = v[DEPTH-1];
  assign out_data  = d[DEPTH-1];

  a_no_blind_accept: assert property (@(posedge CLK) disable iff (!nRST)
    (ld[0] && !skid_v) |-> (in_valid && in_ready));
  a_bubble_out: assert property (@(posedge CLK) disable iff (!nRST)
    !out_valid |-> (out_data == BUBBLE));
  a_occ_exact: assert property (@(posedge CLK) disable iff (!nRST)
    int'(occupancy) == ($countones(v) + int'(skid_v)));

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench for pipe_stage_reg: three configurations, expected words queued at issue
// and popped by per-instance monitors whenever a dequeue is presented.
module tb_pipe_stage_reg;
  import cpu_types_pkg::*;

  logic CLK = 1'b0;
  always #5 CLK = ~CLK;
  logic nRST;

  int checks = 0;
  int failures = 0;
  int occ1 [7] = '{0, 1, 2, 3, 2, 1, 0};

  logic        a_iv, a_ir, a_fl, a_ov, a_or;
  logic [31:0] a_id, a_od;
  logic [2:0]  a_fm;
  logic [1:0]  a_occ;
  flush_cnt_t  a_fc;

  logic        b_iv, b_ir, b_fl, b_ov, b_or;
  logic [31:0] b_id, b_od;
  logic [1:0]  b_fm;
  logic [1:0]  b_occ;
  flush_cnt_t  b_fc;

  logic        c_iv, c_ir, c_fl, c_ov, c_or;
  logic [31:0] c_id, c_od;
  logic [0:0]  c_fm;
  logic [1:0]  c_occ;
  flush_cnt_t  c_fc;

  logic [31:0] qa[$];
  logic [31:0] qb[$];
  logic [31:0] qc[$];

  pipe_stage_reg #(.DW(32), .DEPTH(3), .BUBBLE(32'h0), .SKID(0)) u_a (
    .CLK(CLK), .nRST(nRST), .in_valid(a_iv), .in_ready(a_ir), .in_data(a_id),
    .flush(a_fl), .flush_mask(a_fm), .out_valid(a_ov), .out_ready(a_or),
    .out_data(a_od), .occupancy(a_occ), .flush_cnt(a_fc));

  pipe_stage_reg #(.DW(32), .DEPTH(2), .BUBBLE(32'h0), .SKID(0)) u_b (
    .CLK(CLK), .nRST(nRST), .in_valid(b_iv), .in_ready(b_ir), .in_data(b_id),
    .flush(b_fl), .flush_mask(b_fm), .out_valid(b_ov), .out_ready(b_or),
    .out_data(b_od), .occupancy(b_occ), .flush_cnt(b_fc));

  pipe_stage_reg #(.DW(32), .DEPTH(1), .BUBBLE(32'h0), .SKID(1)) u_c (
    .CLK(CLK), .nRST(nRST), .in_valid(c_iv), .in_ready(c_ir), .in_data(c_id),
    .flush(c_fl), .flush_mask(c_fm), .out_valid(c_ov), .out_ready(c_or),
    .out_data(c_od), .occupancy(c_occ), .flush_cnt(c_fc));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic next_cyc;
    @(posedge CLK);
    #1;
  endtask

  always @(negedge CLK) begin
    if (a_ov && a_or) begin
      if (qa.size() == 0) begin
        checks++; failures++;
        $display("FAIL a_extra_out: got %0h with nothing expected", a_od);
      end else chk("a_out_data", a_od, qa.pop_front());
    end else if (!a_ov) chk("a_bubble", a_od, 32'h0);
  end

  always @(negedge CLK) begin
    if (b_ov && b_or) begin
      if (qb.size() == 0) begin
        checks++; failures++;
        $display("FAIL b_extra_out: got %0h with nothing expected", b_od);
      end else chk("b_out_data", b_od, qb.pop_front());
    end else if (!b_ov) chk("b_bubble", b_od, 32'h0);
  end

  always @(negedge CLK) begin
    if (c_ov && c_or) begin
      if (qc.size() == 0) begin
        checks++; failures++;
        $display("FAIL c_extra_out: got %0h with nothing expected", c_od);
      end else chk("c_out_data", c_od, qc.pop_front());
    end else if (!c_ov) chk("c_bubble", c_od, 32'h0);
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, checks=%0d", checks);
    $fatal(1);
  end

  initial begin
    logic r0;
    int   nxt;
    nRST = 1'b0;
    a_iv = 0; a_id = 0; a_fl = 0; a_fm = 0; a_or = 1;
    b_iv = 0; b_id = 0; b_fl = 0; b_fm = 0; b_or = 1;
    c_iv = 0; c_id = 0; c_fl = 0; c_fm = 0; c_or = 1;
    #12;
    chk("rst_a_in_ready", a_ir, 0);
    chk("rst_c_in_ready", c_ir, 0);
    chk("rst_a_out_valid", a_ov, 0);
    chk("rst_a_occ", a_occ, 0);
    chk("rst_a_flush_cnt", a_fc, 0);
    chk("rst_a_out_data", a_od, 0);
    @(negedge CLK);
    nRST = 1'b1;
    #1;
    chk("rel_a_in_ready", a_ir, 1);
    chk("rel_c_in_ready", c_ir, 1);
    next_cyc();

    // Stream 1,2,3 through DEPTH=3 with no stall
    for (int k = 0; k < 7; k++) begin
      a_iv = (k < 3);
      a_id = (k < 3) ? 32'(k + 1) : 32'h0;
      if (k < 3) qa.push_back(32'(k + 1));
      @(negedge CLK);
      chk("t1_out_valid", a_ov, (k >= 3 && k <= 5));
      chk("t1_occ", a_occ, occ1[k]);
      if (k < 3) chk("t1_in_ready", a_ir, 1);
      next_cyc();
    end
    a_iv = 0;

    // DEPTH=2 stall then release with a same-cycle accept
    b_or = 0; b_iv = 1; b_id = 32'hA; qb.push_back(32'hA);
    @(negedge CLK); chk("t2_rdy_a", b_ir, 1); next_cyc();
    b_id = 32'hB; qb.push_back(32'hB);
    @(negedge CLK); chk("t2_rdy_b", b_ir, 1); next_cyc();
    b_iv = 0; b_id = 0;
    for (int k = 0; k < 5; k++) begin
      @(negedge CLK);
      chk("t2_hold_data", b_od, 32'hA);
      chk("t2_hold_valid", b_ov, 1);
      chk("t2_hold_ready", b_ir, 0);
      chk("t2_hold_occ", b_occ, 2);
      next_cyc();
    end
    b_or = 1; b_iv = 1; b_id = 32'hC; qb.push_back(32'hC);
    @(negedge CLK); chk("t2_rdy_full_deq", b_ir, 1); next_cyc();
    b_iv = 0; b_id = 0;
    @(negedge CLK); chk("t2_occ_const", b_occ, 2); next_cyc();
    repeat (3) next_cyc();

    // DEPTH=3 full, squash the middle slot
    a_or = 0;
    for (int k = 0; k < 3; k++) begin
      a_iv = 1; a_id = 32'h10 + 32'(k);
      next_cyc();
    end
    qa.push_back(32'h10); qa.push_back(32'h12);
    a_iv = 0; a_id = 0; a_fm = 3'b010;
    @(negedge CLK); chk("t3_occ_full", a_occ, 3); next_cyc();
    a_fm = 3'b000; a_or = 1;
    @(negedge CLK); chk("t3_occ_after", a_occ, 2); next_cyc();
    repeat (4) next_cyc();

    // Flush while full with input presented
    a_or = 0;
    for (int k = 0; k < 3; k++) begin
      a_iv = 1; a_id = 32'h21 + 32'(k);
      next_cyc();
    end
    a_fl = 1; a_iv = 1; a_id = 32'h55;
    @(negedge CLK);
    chk("t4_flush_rdy", a_ir, 0);
    chk("t4_occ_pre", a_occ, 3);
    next_cyc();
    a_fl = 0; a_iv = 0; a_id = 0; a_or = 1;
    @(negedge CLK);
    chk("t4_occ", a_occ, 0);
    chk("t4_out_valid", a_ov, 0);
    chk("t4_out_data", a_od, 0);
    chk("t4_flush_cnt", a_fc, 1);
    next_cyc();
    repeat (4) next_cyc();

    // SKID=1 DEPTH=1 with out_ready toggling
    for (int v = 1; v <= 8; v++) qc.push_back(32'(v));
    nxt = 1;
    for (int k = 0; k < 60 && nxt <= 8; k++) begin
      c_iv = 1; c_id = 32'(nxt); c_or = (k % 2 == 0);
      #1; r0 = c_ir; c_or = !c_or;
      #1; chk("t5_ready_indep", c_ir, r0); c_or = !c_or;
      @(negedge CLK);
      chk("t5_occ_bound", (c_occ <= 2), 1);
      if (c_ir) nxt++;
      next_cyc();
    end
    chk("t5_all_accepted", nxt, 9);
    c_iv = 0; c_id = 0; c_or = 1;
    repeat (6) next_cyc();

    // Async reset mid-stream with two entries held
    a_or = 0; a_iv = 1; a_id = 32'h31; next_cyc();
    a_id = 32'h32; next_cyc();
    a_iv = 0; a_id = 0; next_cyc();
    #2; nRST = 1'b0; #1;
    chk("t6_rst_out_valid", a_ov, 0);
    chk("t6_rst_occ", a_occ, 0);
    chk("t6_rst_out_data", a_od, 0);
    chk("t6_rst_flush_cnt", a_fc, 0);
    @(negedge CLK); #2; nRST = 1'b1;
    next_cyc();
    a_or = 1; a_iv = 1; a_id = 32'h40; qa.push_back(32'h40);
    for (int r = 0; r < 4; r++) begin
      @(negedge CLK);
      if (r == 0) chk("t6_rdy", a_ir, 1);
      chk("t6_latency", a_ov, (r == 3));
      next_cyc();
      a_iv = 0; a_id = 0;
    end
    repeat (2) next_cyc();

    chk("qa_drained", qa.size(), 0);
    chk("qb_drained", qb.size(), 0);
    chk("qc_drained", qc.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
